i2c_master_engine: RTL
======================

// Module: i2c_master_engine
// PURPOSE
//  Parametrised I2C byte-level master engine; successor to the fixed-rate single-byte engine.
//  Executes START/repeated-START, STOP, WRITE (captures ACK) and READ with selectable ACK/NACK.
//  Drives open-drain SCL/SDA enables and supports slave clock stretching with a timeout.
//  Sits between a command sequencer (sensor/display drivers) and the top-level I2C pads.
// PARAMETERS
//  CLK_DIV_W  7   phase-counter width; one bit slot = 2^CLK_DIV_W clk, quarter Q = 2^(CLK_DIV_W-2)
//  TIMEOUT_W  16  stretch-timeout counter width; abort after 2^TIMEOUT_W-1 stalled cycles
// PORTS
//  clk          in   1  system clock
//  rst_n        in   1  asynchronous active-low reset
//  cmd_valid    in   1  command request
//  cmd_ready    out  1  engine idle, command accepted when cmd_valid&&cmd_ready
//  cmd          in   3  000 START, 001 STOP, 010 WRITE, 011 READ_ACK, 100 READ_NACK
//  tx_byte      in   8  WRITE data, sampled at accept, sent MSB first
//  rx_byte      out  8  READ data, updated in the done cycle
//  ack_received out  1  WRITE result: 1 = slave pulled SDA low in the ACK slot
//  done         out  1  one-cycle pulse at command completion
//  cmd_err      out  1  one-cycle pulse with done for illegal/invalid commands
//  busy         out  1  high from accept cycle+1 until done
//  bus_owned    out  1  high after START, low after STOP/abort
//  timeout_err  out  1  sticky; cleared on next accepted command
//  sda_in       in   1  SDA pad input (2-flop synchronised internally)
//  sda_oe       out  1  1 = drive SDA low, 0 = release
//  scl_in       in   1  SCL pad input (2-flop synchronised internally)
//  scl_oe       out  1  1 = drive SCL low, 0 = release
// BEHAVIOUR
//  Reset (async, rst_n=0): sda_oe=scl_oe=0 immediately, rx_byte=0, ack_received=0, done=0,
//   cmd_err=0, busy=0, bus_owned=0, timeout_err=0, cmd_ready=1, state IDLE. Reset mid-command
//   releases both lines at once; no STOP is generated.
//  States: IDLE, START, STOP, DATA (slot counter 0..8). Phase counter p, quarter = p[MSB:MSB-1].
//  Accept at cycle T: tx_byte/cmd latched, cmd_ready=0. Phase cycles T+1..T+N*4Q (N = 1 START/
//   STOP, 9 WRITE/READ); done=1 and cmd_ready=1 at T+N*4Q+1 plus any stretch cycles.
//  START q0: scl_oe=bus_owned (repeated start holds SCL low), sda_oe=0; q1: scl_oe=0, sda_oe=0;
//   q2: sda_oe=1; q3: scl_oe=1. bus_owned=1 at done.
//  STOP q0: scl_oe=1, sda_oe=1; q1: scl_oe=0; q2: sda_oe=0; q3: lines released. bus_owned=0.
//  Bit slot: q0 scl_oe=1, sda_oe=~bit (READ data bits: sda_oe=0); q1 scl_oe=0; q2 SCL high,
//   sda_in sampled on first q2 cycle; q3 scl_oe=1. Slot 8 = ACK: WRITE releases SDA and sets
//   ack_received=~sda; READ_ACK drives sda_oe=1, READ_NACK releases.
//  SDA changes only while SCL is driven low, except START q2 and STOP q2.
//  Stretching: on last q1 cycle, if synchronised scl_in==0, p holds; stall counter increments.
//   Stall counter clears when p advances. Reaching 2^TIMEOUT_W-1: release both lines,
//   bus_owned=0, timeout_err=1, done pulse, return IDLE.
//  WRITE/READ/STOP with bus_owned=0, or cmd 101-111: no bus activity, done+cmd_err at T+1.
//  cmd_valid while busy is ignored (not accepted). Illegal/idle: lines keep prior level.
//  rx_byte/ack_received hold value until the next matching command completes.
// TESTING
//  START idle, Q=32: SDA falls at T+65, SCL falls at T+97, done at T+129, bus_owned=1.
//  WRITE 0xA5, slave ACK: SDA bits 1,0,1,0,0,1,0,1 stable while SCL high; done at T+1153, ack=1.
//  READ_NACK, slave sends 0x3C: rx_byte=0x3C at done, SDA released in slot 8; READ_ACK drives 0.
//  Slave holds SCL low 200 cycles in slot 3: done delayed exactly 200 cycles, data intact.
//  TIMEOUT_W=4, SCL stuck low: abort after 15 stalls, lines released, timeout_err=1, done pulse.
//  WRITE when not owned -> done+cmd_err at T+1; rst_n low mid-WRITE -> oe=0 same cycle.

Source files
------------

// File: rtl/i2c_master_engine_if.sv
// I2C master engine command/status and pad bundle.
// The engine takes the slave side of the command handshake.
interface i2c_master_engine_if;
  logic       cmd_valid;
  logic       cmd_ready;
  logic [2:0] cmd;
  logic [7:0] tx_byte;
  logic [7:0] rx_byte;
  logic       ack_received;
  logic       done;
  logic       cmd_err;
  logic       busy;
  logic       bus_owned;
  logic       timeout_err;
  logic       sda_in;
  logic       sda_oe;
  logic       scl_in;
  logic       scl_oe;

  modport master (
    output cmd_valid, cmd, tx_byte, sda_in, scl_in,
    input  cmd_ready, rx_byte, ack_received, done, cmd_err,
    input  busy, bus_owned, timeout_err, sda_oe, scl_oe
  );

  modport slave (
    input  cmd_valid, cmd, tx_byte, sda_in, scl_in,
    output cmd_ready, rx_byte, ack_received, done, cmd_err,
    output busy, bus_owned, timeout_err, sda_oe, scl_oe
  );
endinterface

// File: rtl/i2c_master_engine.sv
// Byte-level I2C master: START/STOP/WRITE/READ with
// open-drain enables, clock stretching and stall timeout.
module i2c_master_engine #(
  parameter int CLK_DIV_W = 7,
  parameter int TIMEOUT_W = 16
) (
  input logic clk,
  input logic rst_n,
  i2c_master_engine_if.slave bus
);
  localparam int W = CLK_DIV_W;
  localparam logic [W-1:0] P_Q1E = {1'b0, {(W-1){1'b1}}};
  localparam logic [W-1:0] P_Q2 = {1'b1, {(W-1){1'b0}}};
  localparam logic [W-1:0] P_END = '1;
  localparam logic [TIMEOUT_W-1:0] ST_LAST =
    {{(TIMEOUT_W-1){1'b1}}, 1'b0};
  localparam logic [2:0] C_START = 3'd0;
  localparam logic [2:0] C_STOP = 3'd1;
  localparam logic [2:0] C_WR = 3'd2;
  localparam logic [2:0] C_RDA = 3'd3;
  localparam logic [2:0] C_RDN = 3'd4;

  typedef enum logic [1:0] {IDLE, START, STOP, DATA} state_t;

  state_t state;
  state_t new_st;
  logic [W-1:0] p;
  logic [W-1:0] p_nx;
  logic [3:0] slot;
  logic [3:0] slot_nx;
  logic [TIMEOUT_W-1:0] stall;
  logic [2:0] op;
  logic [7:0] tx_q;
  logic [7:0] rx_sh;
  logic ack_cap;
  logic [1:0] scl_sync;
  logic [1:0] sda_sync;
  logic illegal;
  logic stretch;
  logic finish;
  logic [1:0] oe_nx;
  logic [1:0] oe_new;

  // Line levels {scl_oe, sda_oe} for a given state, quarter and slot.
  function automatic logic [1:0] oe_of(state_t st, logic [1:0] q,
    logic [3:0] sl, logic [2:0] c, logic [7:0] tx, logic own);
    logic d;
    logic [1:0] r;
    d = sl[3] ? (c == C_RDA) : ((c == C_WR) && !tx[3'(4'd7 - sl)]);
    r = 2'b00;
    case (st)
      START: begin
        case (q)
          2'd0: r = {own, 1'b0};
          2'd1: r = 2'b00;
          2'd2: r = 2'b01;
          default: r = 2'b11;
        endcase
      end
      STOP: begin
        case (q)
          2'd0: r = 2'b11;
          2'd1: r = 2'b01;
          default: r = 2'b00;
        endcase
      end
      DATA: begin
        case (q)
          2'd0, 2'd3: r = {1'b1, d};
          default: r = {1'b0, d};
        endcase
      end
      default: r = 2'b00;
    endcase
    return r;
  endfunction

  // Two-flop synchronisers for the pad inputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      scl_sync <= 2'b11;
      sda_sync <= 2'b11;
    end else begin
      scl_sync <= {scl_sync[0], bus.scl_in};
      sda_sync <= {sda_sync[0], bus.sda_in};
    end
  end

  // Command decode, phase advance and next line levels.
  always_comb begin
    new_st = IDLE;
    illegal = 1'b1;
    case (bus.cmd)
      C_START: begin
        new_st = START;
        illegal = 1'b0;
      end
      C_STOP: begin
        new_st = STOP;
        illegal = !bus.bus_owned;
      end
      C_WR, C_RDA, C_RDN: begin
        new_st = DATA;
        illegal = !bus.bus_owned;
      end
      default: ;
    endcase
    p_nx = p + 1'b1;
    slot_nx = (p == P_END) ? slot + 4'd1 : slot;
    stretch = (state != IDLE) && (p == P_Q1E) && !scl_sync[1];
    finish = (p == P_END) && ((state != DATA) || (slot == 4'd8));
    oe_nx = oe_of(state, p_nx[W-1 -: 2], slot_nx, op, tx_q,
                  bus.bus_owned);
    oe_new = oe_of(new_st, 2'b00, 4'd0, bus.cmd, bus.tx_byte,
                   bus.bus_owned);
  end

  // Engine FSM with registered line enables and status.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      p <= '0;
      slot <= '0;
      stall <= '0;
      op <= '0;
      tx_q <= '0;
      rx_sh <= '0;
      ack_cap <= 1'b0;
      bus.cmd_ready <= 1'b1;
      bus.rx_byte <= '0;
      bus.ack_received <= 1'b0;
      bus.done <= 1'b0;
      bus.cmd_err <= 1'b0;
      bus.busy <= 1'b0;
      bus.bus_owned <= 1'b0;
      bus.timeout_err <= 1'b0;
      bus.scl_oe <= 1'b0;
      bus.sda_oe <= 1'b0;
    end else begin
      bus.done <= 1'b0;
      bus.cmd_err <= 1'b0;
      if (state == IDLE) begin
        if (bus.cmd_valid && bus.cmd_ready) begin
          bus.timeout_err <= 1'b0;
          if (illegal) begin
            bus.done <= 1'b1;
            bus.cmd_err <= 1'b1;
          end else begin
            state <= new_st;
            op <= bus.cmd;
            tx_q <= bus.tx_byte;
            p <= '0;
            slot <= '0;
            stall <= '0;
            bus.cmd_ready <= 1'b0;
            bus.busy <= 1'b1;
            {bus.scl_oe, bus.sda_oe} <= oe_new;
          end
        end
      end else if (stretch) begin
        if (stall == ST_LAST) begin
          state <= IDLE;
          bus.scl_oe <= 1'b0;
          bus.sda_oe <= 1'b0;
          bus.bus_owned <= 1'b0;
          bus.timeout_err <= 1'b1;
          bus.done <= 1'b1;
          bus.cmd_ready <= 1'b1;
          bus.busy <= 1'b0;
        end else begin
          stall <= stall + 1'b1;
        end
      end else begin
        stall <= '0;
        p <= p_nx;
        if (state == DATA && p == P_Q2) begin
          if (slot[3]) ack_cap <= !sda_sync[1];
          else rx_sh <= {rx_sh[6:0], sda_sync[1]};
        end
        if (finish) begin
          state <= IDLE;
          bus.done <= 1'b1;
          bus.cmd_ready <= 1'b1;
          bus.busy <= 1'b0;
          case (state)
            START: bus.bus_owned <= 1'b1;
            STOP: bus.bus_owned <= 1'b0;
            default: begin
              if (op == C_WR) bus.ack_received <= ack_cap;
              else bus.rx_byte <= rx_sh;
            end
          endcase
        end else begin
          slot <= slot_nx;
          {bus.scl_oe, bus.sda_oe} <= oe_nx;
        end
      end
    end
  end
endmodule
